// File: rtl/bcd_disp_pkg.sv
// +----------------------------------------------------------------------------+
// | bcd_disp_pkg : shared types and constants for the BCD scan display         |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package bcd_disp_pkg;

  typedef enum logic [1:0] {
    S_UNITS = 2'd0,
    S_TENS  = 2'd1,
    S_HUNDS = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [2:0] AN_OFF   = 3'b111;
  localparam logic [2:0] AN_UNITS = 3'b110;
  localparam logic [2:0] AN_TENS  = 3'b101;
  localparam logic [2:0] AN_HUNDS = 3'b011;

  function automatic logic [2:0] anode_for(input state_t s);
    case (s)
      S_UNITS: return AN_UNITS;
      S_TENS:  return AN_TENS;
      S_HUNDS: return AN_HUNDS;
      default: return AN_OFF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// +----------------------------------------------------------------------------+
// | seg7_decode : BCD digit to active-low {g,f,e,d,c,b,a}, dash for 10-15      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bcd_scan_display.sv
// +----------------------------------------------------------------------------+
// | bcd_scan_display : 3-digit multiplexed common-anode display with blank gap |
// | Optional macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens.    |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] Units,
  input  logic [3:0] Tens,
  input  logic [3:0] Hunds,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int MAX_CYC = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_nxt;
  state_t           next_dig, next_dig_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       sh_units, sh_tens, sh_hunds;
  logic [6:0]       seg_nxt;
  logic [2:0]       an_nxt;
  logic [3:0]       sel_digit;
  logic [6:0]       dec_seg;
  logic             blank;

  // The decoder always looks at the digit that the next gap exit will light.
  always_comb begin
    sel_digit = sh_units;
    case (next_dig)
      S_TENS:  sel_digit = sh_tens;
      S_HUNDS: sel_digit = sh_hunds;
      default: sel_digit = sh_units;
    endcase
  end

  seg7_decode u_decode (
    .digit (sel_digit),
    .seg   (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign blank = ((next_dig == S_HUNDS) && (sh_hunds == 4'd0)) ||
                 ((next_dig == S_TENS) && (sh_hunds == 4'd0) && (sh_tens == 4'd0));
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    next_dig_nxt = next_dig;
    cnt_nxt      = cnt + 1'b1;
    seg_nxt      = seg;
    an_nxt       = an;
    if (state == S_GAP) begin
      if (cnt == GAP_LAST) begin
        state_nxt = next_dig;
        cnt_nxt   = '0;
        seg_nxt   = blank ? SEG_OFF : dec_seg;
        an_nxt    = blank ? AN_OFF  : anode_for(next_dig);
        case (next_dig)
          S_UNITS: next_dig_nxt = S_TENS;
          S_TENS:  next_dig_nxt = S_HUNDS;
          default: next_dig_nxt = S_UNITS;
        endcase
      end
    end else if (cnt == DIGIT_LAST) begin
      state_nxt = S_GAP;
      cnt_nxt   = '0;
      seg_nxt   = SEG_OFF;
      an_nxt    = AN_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_GAP;
      next_dig <= S_UNITS;
      cnt      <= '0;
      seg      <= SEG_OFF;
      an       <= AN_OFF;
      sh_units <= 4'd0;
      sh_tens  <= 4'd0;
      sh_hunds <= 4'd0;
    end else begin
      state    <= state_nxt;
      next_dig <= next_dig_nxt;
      cnt      <= cnt_nxt;
      seg      <= seg_nxt;
      an       <= an_nxt;
      if (load) begin
        sh_units <= Units;
        sh_tens  <= Tens;
        sh_hunds <= Hunds;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
// +----------------------------------------------------------------------------+
// | tb_bcd_scan_display : self-checking bench against a time-position model    |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bcd_scan_display;

  localparam int RD     = 4;
  localparam int GC     = 2;
  localparam int SLOT   = RD + GC;
  localparam int PERIOD = 3 * SLOT;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       load  = 1'b0;
  logic [3:0] units = 4'd0;
  logic [3:0] tens  = 4'd0;
  logic [3:0] hunds = 4'd0;
  logic [6:0] seg;
  logic [2:0] an;

  int tests = 0;
  int fails = 0;

  bcd_scan_display #(.REFRESH_DIV(RD), .GAP_CYCLES(GC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .Units (units),
    .Tens  (tens),
    .Hunds (hunds),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  // Reference model: position in the scan is derived from cycles since reset.
  logic [3:0] m_sh [0:2];
  int         m_t, m_p, m_idx;
  logic [6:0] m_lit;
  logic       m_blank;
  logic [6:0] exp_seg;
  logic [2:0] exp_an;

  function automatic logic [6:0] ref_decode(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_t = 0; m_p = 0; m_idx = 0;
      m_sh[0] = 4'd0; m_sh[1] = 4'd0; m_sh[2] = 4'd0;
      m_lit = 7'h7F; m_blank = 1'b0;
      exp_seg = 7'h7F; exp_an = 3'b111;
    end else begin
      m_t   = m_t + 1;
      m_p   = m_t % SLOT;
      m_idx = (m_t / SLOT) % 3;
      if (m_p == GC) begin
        m_lit   = ref_decode(m_sh[m_idx]);
        m_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (m_idx == 2 && m_sh[2] == 4'd0) m_blank = 1'b1;
        if (m_idx == 1 && m_sh[2] == 4'd0 && m_sh[1] == 4'd0) m_blank = 1'b1;
`endif
      end
      if (load) begin
        m_sh[0] = units; m_sh[1] = tens; m_sh[2] = hunds;
      end
      if (m_p < GC || m_blank) begin
        exp_seg = 7'h7F; exp_an = 3'b111;
      end else begin
        exp_seg = m_lit; exp_an = ~(3'b001 << m_idx);
      end
    end
  end

  task automatic pulse_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    hunds = h; tens = t; units = u; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_units_entry(input string tag);
    int guard = 0;
    while (!(m_idx == 0 && m_p == GC) && guard < 2 * PERIOD) begin
      @(posedge clk); #1;
      guard++;
    end
    tests++;
    if (guard >= 2 * PERIOD) begin
      fails++;
      $display("FAIL %s wait: units slot not reached within %0d cycles", tag, 2 * PERIOD);
    end
  endtask

  task automatic test_reset();
    logic [2:0] an_tab [0:5];
    an_tab[0] = 3'b111; an_tab[1] = 3'b111;
    an_tab[2] = 3'b110; an_tab[3] = 3'b110; an_tab[4] = 3'b110; an_tab[5] = 3'b110;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      tests++;
      if (seg !== 7'h7F || an !== 3'b111) begin
        fails++;
        $display("FAIL reset_hold: seg=%b an=%b, expected seg=1111111 an=111", seg, an);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      tests++;
      if (an !== an_tab[c] || an !== exp_an || seg !== exp_seg) begin
        fails++;
        $display("FAIL reset_release cycle %0d: an=%b seg=%b, expected an=%b seg=%b",
                 c + 1, an, seg, an_tab[c], exp_seg);
      end
    end
  endtask

  task automatic test_number_255();
    logic [2:0] an_tab  [0:2];
    logic [6:0] seg_tab [0:2];
    an_tab[0] = 3'b110; seg_tab[0] = 7'b0010010;
    an_tab[1] = 3'b101; seg_tab[1] = 7'b0010010;
    an_tab[2] = 3'b011; seg_tab[2] = 7'b0100100;
    pulse_load(4'd2, 4'd5, 4'd5);
    @(posedge clk); #1;
    wait_units_entry("n255");
    for (int c = 0; c < PERIOD; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      tests++;
      if (m_p < GC) begin
        if (an !== 3'b111 || seg !== 7'h7F) begin
          fails++;
          $display("FAIL n255_gap: an=%b seg=%b, expected an=111 seg=1111111", an, seg);
        end
      end else if (an !== an_tab[m_idx] || seg !== seg_tab[m_idx]) begin
        fails++;
        $display("FAIL n255_digit%0d: an=%b seg=%b, expected an=%b seg=%b",
                 m_idx, an, seg, an_tab[m_idx], seg_tab[m_idx]);
      end
    end
  endtask

  task automatic test_load_mid_slot();
    wait_units_entry("midslot");
    @(posedge clk); #1;
    pulse_load(4'd2, 4'd5, 4'd7);
    while (m_idx == 0 && m_p >= GC) begin
      tests++;
      if (seg !== 7'b0010010 || an !== 3'b110) begin
        fails++;
        $display("FAIL midslot_hold: seg=%b an=%b, expected seg=0010010 an=110", seg, an);
      end
      @(posedge clk); #1;
    end
    wait_units_entry("midslot_next");
    tests++;
    if (seg !== 7'b1111000 || an !== 3'b110) begin
      fails++;
      $display("FAIL midslot_new: seg=%b an=%b, expected seg=1111000 an=110", seg, an);
    end
  endtask

  task automatic test_out_of_range();
    pulse_load(4'd1, 4'd3, 4'hC);
    @(posedge clk); #1;
    wait_units_entry("oor");
    tests++;
    if (seg !== 7'b0111111 || an !== 3'b110) begin
      fails++;
      $display("FAIL oor_units: seg=%b an=%b, expected seg=0111111 an=110", seg, an);
    end
  endtask

  task automatic test_leading_zero();
    pulse_load(4'd0, 4'd0, 4'd7);
    @(posedge clk); #1;
    wait_units_entry("lz");
    for (int c = 0; c < PERIOD; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (m_idx != 0 && m_p >= GC) begin
        tests++;
`ifdef LEADING_ZERO_BLANK_EN
        if (an !== 3'b111) begin
          fails++;
          $display("FAIL lz_blank digit%0d: an=%b, expected an=111", m_idx, an);
        end
`else
        if (an !== ((m_idx == 1) ? 3'b101 : 3'b011) || seg !== 7'b1000000) begin
          fails++;
          $display("FAIL lz_shown digit%0d: an=%b seg=%b, expected seg=1000000", m_idx, an, seg);
        end
`endif
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      load  = ($urandom_range(0, 3) == 0);
      units = 4'($urandom);
      tens  = 4'($urandom);
      hunds = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      @(posedge clk); #1;
      tests++;
      if (seg !== exp_seg || an !== exp_an) begin
        fails++;
        $display("FAIL random cycle %0d: seg=%b an=%b, expected seg=%b an=%b",
                 c, seg, an, exp_seg, exp_an);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    pulse_load(4'd2, 4'd4, 4'd6);
    while (!(m_idx == 1 && m_p > GC) && guard < 2 * PERIOD) begin
      @(posedge clk); #1;
      guard++;
    end
    tests++;
    if (guard >= 2 * PERIOD) begin
      fails++;
      $display("FAIL midreset wait: tens slot not reached");
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (seg !== 7'h7F || an !== 3'b111) begin
      fails++;
      $display("FAIL midreset_apply: seg=%b an=%b, expected seg=1111111 an=111", seg, an);
    end
    rst_n = 1'b1;
    for (int c = 0; c < PERIOD; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      tests++;
      if (seg !== exp_seg || an !== exp_an ||
          (c == GC && (seg !== 7'b1000000 || an !== 3'b110))) begin
        fails++;
        $display("FAIL midreset_restart cycle %0d: seg=%b an=%b, expected seg=%b an=%b",
                 c + 1, seg, an, exp_seg, exp_an);
      end
    end
  endtask

  initial begin
    test_reset();
    test_number_255();
    test_load_mid_slot();
    test_out_of_range();
    test_leading_zero();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the binary-to-BCD converter: takes its Units/Tens/Hunds digits and drives a 3-digit multiplexed common-anode 7-segment display.
- Holds a shadow copy of the digits, loaded on a strobe, so the display stays stable while the converter input changes.
- Time-multiplexes the digits, with an anti-ghosting blank gap between digit slots.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit's anode is active (≥1).
- GAP_CYCLES, 4, clock cycles all anodes are off between digit slots (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- load  in  1  when high, latch Units/Tens/Hunds into shadow registers.
- Units  in  4  BCD ones digit.
- Tens  in  4  BCD tens digit.
- Hunds  in  4  BCD hundreds digit (converter produces 0-2; all 16 codes handled).
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  3  digit anodes {hunds,tens,units}, active-low one-hot or all-off.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n low at a clk edge):
  - seg=7'h7F, an=3'b111, shadow digits=0.
  - FSM enters S_GAP with next digit = Units; slot counter = 0.
- Mid-operation reset takes effect at the next edge regardless of state.
- FSM states: S_UNITS, S_TENS, S_HUNDS, S_GAP.
  - Order: GAP→UNITS→GAP→TENS→GAP→HUNDS→GAP→UNITS...
  - Digit states last exactly REFRESH_DIV cycles; S_GAP lasts exactly GAP_CYCLES cycles.
  - Counter width: $clog2(max(REFRESH_DIV,GAP_CYCLES)+1).
- Outputs are registered:
  - On the edge entering a digit state, seg takes the decode of the corresponding shadow digit and the matching an bit goes low.
  - On the edge entering S_GAP, an=111 and seg=7'h7F.
  - First Units illumination occurs GAP_CYCLES cycles after reset release.
- Load:
  - load sampled each edge; shadow registers update the same edge.
  - Continuous load latches every cycle.
  - seg is sampled only at slot entry, so a load mid-slot never changes the currently lit digit; new values appear from the next slot for that digit.
- Decode: 0-9 standard patterns (0=7'b1000000, 5=7'b0010010, 7=7'b1111000); codes 10-15 show dash 7'b0111111.
- load has no effect while rst_n is low.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - Hunds shadow==0 keeps an[2] high during S_HUNDS.
  - Hunds==0 and Tens==0 also keeps an[1] high during S_TENS.
  - Units is never blanked.
  - Slot timing is unchanged, so brightness does not vary.
- Undefined: all three digits are always lit, with zeros shown.

Decomposition:
- Package bcd_disp_pkg:
  - state enum (S_UNITS, S_TENS, S_HUNDS, S_GAP);
  - constants SEG_OFF=7'h7F and SEG_DASH=7'b0111111;
  - anode one-hot constants.
- Sub-module seg7_decode: combinational 4-bit→7-bit active-low decode.
  - Instantiated once, fed by a mux of the shadow digits on the next-digit select.

Test Plan (REFRESH_DIV=4, GAP_CYCLES=2):
1. Reset: rst_n low 3 cycles → seg=7F, an=111. After release: cycles 1-2 an=111, cycles 3-6 an=110.
2. Number 255: load=1 one cycle with H=2, T=5, U=5 → an=110/seg=0010010 (4 cycles), gap, an=101/seg=0010010, gap, an=011/seg=0100100.
3. Load mid-slot: in cycle 2 of the Units slot load U=7 → seg stays 0010010 until that slot ends; next Units slot shows 1111000.
4. Out-of-range digit: U=4'hC → Units slot seg=0111111.
5. Leading zeros, H=0, T=0, U=7:
   - with LEADING_ZERO_BLANK_EN: an stays 111 through the Tens and Hunds slots;
   - without it: an=101 and an=011 each show seg=1000000.
6. Reset mid-slot: drop rst_n during S_TENS → next edge seg=7F, an=111, shadow=0. After release the scan restarts with gap then Units showing 1000000.
